// File: rtl/st7735_panel_receiver_pkg.sv
// Shared definitions for the ST7735 panel receiver.
//  - ST7735 command opcodes understood by the decoder
//  - decoder FSM state encoding (state_t), also exported on the debug port
package st7735_panel_receiver_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPIN   = 8'h10;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_INVOFF  = 8'h20;
    localparam logic [7:0] CMD_INVON   = 8'h21;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_RASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] CMD_MADCTL  = 8'h36;
    localparam logic [7:0] CMD_COLMOD  = 8'h3A;

    typedef enum logic [2:0] {
        S_CMD    = 3'd0,
        S_CASET  = 3'd1,
        S_RASET  = 3'd2,
        S_RAMWR  = 3'd3,
        S_COLMOD = 3'd4,
        S_MADCTL = 3'd5,
        S_SKIP   = 3'd6
    } state_t;

endpackage

// File: rtl/st7735_panel_receiver_if.sv
// ST7735 4-wire SPI bus as seen at the panel.
//  CS      chip select, active low
//  LCD_CLK serial clock, data sampled on the rising edge
//  MOSI    serial data, MSB first
//  DC      0 = command byte, 1 = data byte (meaningful with bit 0)
//  RESET   panel RESX, active low
// The bus has no handshake: the driver (master) owns every wire and the
// panel (slave) only samples them, so there is no valid/ready pair here.
interface st7735_panel_receiver_if;
    logic CS;
    logic LCD_CLK;
    logic MOSI;
    logic DC;
    logic RESET;

    modport master (output CS, output LCD_CLK, output MOSI, output DC, output RESET);
    modport slave  (input  CS, input  LCD_CLK, input  MOSI, input  DC, input  RESET);
endinterface

// File: rtl/st7735_panel_receiver_spi_rx_shifter.sv
// SPI receive front end: synchronises every bus wire into the system clock
// domain, detects rising LCD_CLK edges while CS is low and assembles
// MSB-first bytes.
// Ports:
//  clk, rst      system clock, asynchronous active-high reset
//  clr           synchronous clear (soft reset from the decoder)
//  bus           SPI bus, slave side
//  byte_valid    1-cycle strobe, byte_data/byte_is_cmd valid
//  byte_data     last assembled byte
//  byte_is_cmd   inverted DC captured with bit 0
//  panel_rst     synchronised RESET wire is low (panel held in reset)
module st7735_panel_receiver_spi_rx_shifter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    st7735_panel_receiver_if.slave       bus,
    output logic                         byte_valid,
    output logic [7:0]                   byte_data,
    output logic                         byte_is_cmd,
    output logic                         panel_rst
);

    // Bit order of the synchroniser word: {rst_n, dc, mosi, sck, cs}.
    // Idle value keeps CS and RESET deasserted right after reset.
    localparam logic [4:0] SYNC_IDLE = 5'b10001;

    logic [4:0] sync_q [SYNC_STAGES];
    logic [4:0] sync_d [SYNC_STAGES];
    logic [4:0] s;

    logic       sck_prev_q,  sck_prev_d;
    logic       rise_q,      rise_d;
    logic       rise_mosi_q, rise_mosi_d;
    logic       rise_dc_q,   rise_dc_d;
    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic [6:0] shift_q,     shift_d;
    logic       byte_valid_q, byte_valid_d;
    logic [7:0] byte_data_q,  byte_data_d;
    logic       byte_is_cmd_q, byte_is_cmd_d;

    assign s         = sync_q[SYNC_STAGES-1];
    assign panel_rst = ~s[4];

    always_comb begin
        sync_d[0] = {bus.RESET, bus.DC, bus.MOSI, bus.LCD_CLK, bus.CS};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end

        // Edge detect is registered; MOSI/DC are captured alongside it so
        // they stay aligned with the edge that sampled them.
        sck_prev_d  = s[1];
        rise_d      = s[1] & ~sck_prev_q & ~s[0];
        rise_mosi_d = s[2];
        rise_dc_d   = s[3];

        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        byte_valid_d  = 1'b0;
        byte_data_d   = byte_data_q;
        byte_is_cmd_d = byte_is_cmd_q;

        if (clr || panel_rst) begin
            rise_d        = 1'b0;
            bit_cnt_d     = 3'd0;
            shift_d       = 7'd0;
            byte_data_d   = 8'd0;
            byte_is_cmd_d = 1'b0;
        end else if (s[0]) begin
            // CS high drops a partial byte without a strobe.
            bit_cnt_d = 3'd0;
        end else if (rise_q) begin
            shift_d   = {shift_q[5:0], rise_mosi_q};
            bit_cnt_d = 3'(bit_cnt_q + 3'd1);
            if (bit_cnt_q == 3'd7) begin
                byte_valid_d  = 1'b1;
                byte_data_d   = {shift_q, rise_mosi_q};
                byte_is_cmd_d = ~rise_dc_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= SYNC_IDLE;
            end
            sck_prev_q    <= 1'b0;
            rise_q        <= 1'b0;
            rise_mosi_q   <= 1'b0;
            rise_dc_q     <= 1'b0;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 7'd0;
            byte_valid_q  <= 1'b0;
            byte_data_q   <= 8'd0;
            byte_is_cmd_q <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            sck_prev_q    <= sck_prev_d;
            rise_q        <= rise_d;
            rise_mosi_q   <= rise_mosi_d;
            rise_dc_q     <= rise_dc_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            byte_valid_q  <= byte_valid_d;
            byte_data_q   <= byte_data_d;
            byte_is_cmd_q <= byte_is_cmd_d;
        end
    end

    assign byte_valid  = byte_valid_q;
    assign byte_data   = byte_data_q;
    assign byte_is_cmd = byte_is_cmd_q;

endmodule

// File: rtl/st7735_panel_receiver.sv
// ST7735 panel-side receiver: decodes the byte stream from the SPI front end
// into commands, parameters and RAMWR pixel writes with (x,y) addresses.
// Ports:
//  SYSTEM_CLK, SYSTEM_RESET  receiver clock, asynchronous active-high reset
//  spi                       SPI bus (CS, LCD_CLK, MOSI, DC, RESET), slave side
//  byte_valid/byte_data/byte_is_cmd   every received byte
//  pix_valid/pix_x/pix_y/pix_data     every completed RGB565 pixel
//  frame_done                         last pixel of the address window
//  sleep_out/display_on/inverted/colmod/madctl   panel status
//  dbg_state                          decoder FSM state
module st7735_panel_receiver
    import st7735_panel_receiver_pkg::*;
#(
    parameter int WIDTH       = 160,
    parameter int HEIGHT      = 80,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      SYSTEM_CLK,
    input  logic                      SYSTEM_RESET,
    st7735_panel_receiver_if.slave    spi,
    output logic                      byte_valid,
    output logic [7:0]                byte_data,
    output logic                      byte_is_cmd,
    output logic                      pix_valid,
    output logic [$clog2(WIDTH)-1:0]  pix_x,
    output logic [$clog2(HEIGHT)-1:0] pix_y,
    output logic [15:0]               pix_data,
    output logic                      frame_done,
    output logic                      sleep_out,
    output logic                      display_on,
    output logic                      inverted,
    output logic [7:0]                colmod,
    output logic [7:0]                madctl,
    output state_t                    dbg_state
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    logic panel_rst;
    logic sw_rst;

    st7735_panel_receiver_spi_rx_shifter #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_shifter (
        .clk         (SYSTEM_CLK),
        .rst         (SYSTEM_RESET),
        .clr         (sw_rst),
        .bus         (spi),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_is_cmd (byte_is_cmd),
        .panel_rst   (panel_rst)
    );

    assign sw_rst = byte_valid && byte_is_cmd && (byte_data == CMD_SWRESET);

    state_t        state_q, state_d;
    logic [1:0]    pcnt_q, pcnt_d;
    logic [7:0]    p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
    logic [XW-1:0] xs_q, xs_d, xe_q, xe_d, x_q, x_d;
    logic [YW-1:0] ys_q, ys_d, ye_q, ye_d, y_q, y_d;
    logic          hi_flag_q, hi_flag_d;
    logic [7:0]    hi_byte_q, hi_byte_d;
    logic          pix_valid_q, pix_valid_d;
    logic [XW-1:0] pix_x_q, pix_x_d;
    logic [YW-1:0] pix_y_q, pix_y_d;
    logic [15:0]   pix_data_q, pix_data_d;
    logic          frame_done_q, frame_done_d;
    logic          sleep_out_q, sleep_out_d;
    logic          display_on_q, display_on_d;
    logic          inverted_q, inverted_d;
    logic [7:0]    colmod_q, colmod_d;
    logic [7:0]    madctl_q, madctl_d;
    logic          x_wrap, y_wrap;

    // Wrap on the window end or the panel edge, whichever comes first, so an
    // inverted window (start > end) still walks a bounded run.
    assign x_wrap = (x_q == xe_q) || (x_q == X_LAST);
    assign y_wrap = (y_q == ye_q) || (y_q == Y_LAST);

    always_comb begin
        state_d      = state_q;
        pcnt_d       = pcnt_q;
        p0_d         = p0_q;
        p1_d         = p1_q;
        p2_d         = p2_q;
        xs_d         = xs_q;
        xe_d         = xe_q;
        ys_d         = ys_q;
        ye_d         = ye_q;
        x_d          = x_q;
        y_d          = y_q;
        hi_flag_d    = hi_flag_q;
        hi_byte_d    = hi_byte_q;
        pix_valid_d  = 1'b0;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_data_d   = pix_data_q;
        frame_done_d = 1'b0;
        sleep_out_d  = sleep_out_q;
        display_on_d = display_on_q;
        inverted_d   = inverted_q;
        colmod_d     = colmod_q;
        madctl_d     = madctl_q;

        if (panel_rst || sw_rst) begin
            state_d      = S_CMD;
            pcnt_d       = 2'd0;
            p0_d         = 8'd0;
            p1_d         = 8'd0;
            p2_d         = 8'd0;
            xs_d         = '0;
            xe_d         = X_LAST;
            ys_d         = '0;
            ye_d         = Y_LAST;
            x_d          = '0;
            y_d          = '0;
            hi_flag_d    = 1'b0;
            hi_byte_d    = 8'd0;
            pix_x_d      = '0;
            pix_y_d      = '0;
            pix_data_d   = 16'd0;
            sleep_out_d  = 1'b0;
            display_on_d = 1'b0;
            inverted_d   = 1'b0;
            colmod_d     = 8'd0;
            madctl_d     = 8'd0;
        end else if (byte_valid) begin
            if (byte_is_cmd) begin
                // A command always aborts whatever was in progress.
                pcnt_d    = 2'd0;
                hi_flag_d = 1'b0;
                state_d   = S_SKIP;
                case (byte_data)
                    CMD_CASET:  state_d = S_CASET;
                    CMD_RASET:  state_d = S_RASET;
                    CMD_RAMWR: begin
                        state_d = S_RAMWR;
                        x_d     = xs_q;
                        y_d     = ys_q;
                    end
                    CMD_COLMOD: state_d = S_COLMOD;
                    CMD_MADCTL: state_d = S_MADCTL;
                    CMD_SLPOUT: sleep_out_d  = 1'b1;
                    CMD_SLPIN:  sleep_out_d  = 1'b0;
                    CMD_DISPON: display_on_d = 1'b1;
                    CMD_DISPOFF: display_on_d = 1'b0;
                    CMD_INVON:  inverted_d   = 1'b1;
                    CMD_INVOFF: inverted_d   = 1'b0;
                    default: ;
                endcase
            end else begin
                case (state_q)
                    S_CASET, S_RASET: begin
                        pcnt_d = 2'(pcnt_q + 2'd1);
                        case (pcnt_q)
                            2'd0: p0_d = byte_data;
                            2'd1: p1_d = byte_data;
                            2'd2: p2_d = byte_data;
                            default: begin
                                // Window registers only change once all four
                                // parameters have arrived.
                                if (state_q == S_CASET) begin
                                    xs_d = XW'({p0_q, p1_q});
                                    xe_d = XW'({p2_q, byte_data});
                                end else begin
                                    ys_d = YW'({p0_q, p1_q});
                                    ye_d = YW'({p2_q, byte_data});
                                end
                                state_d = S_SKIP;
                            end
                        endcase
                    end
                    S_COLMOD: begin
                        colmod_d = byte_data;
                        state_d  = S_SKIP;
                    end
                    S_MADCTL: begin
                        madctl_d = byte_data;
                        state_d  = S_SKIP;
                    end
                    S_RAMWR: begin
                        if (!hi_flag_q) begin
                            hi_flag_d = 1'b1;
                            hi_byte_d = byte_data;
                        end else begin
                            hi_flag_d   = 1'b0;
                            pix_valid_d = 1'b1;
                            pix_x_d     = x_q;
                            pix_y_d     = y_q;
                            pix_data_d  = {hi_byte_q, byte_data};
                            if (x_wrap) begin
                                x_d = xs_q;
                                if (y_wrap) begin
                                    y_d          = ys_q;
                                    frame_done_d = 1'b1;
                                end else begin
                                    y_d = YW'(y_q + YW'(1));
                                end
                            end else begin
                                x_d = XW'(x_q + XW'(1));
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge SYSTEM_CLK or posedge SYSTEM_RESET) begin
        if (SYSTEM_RESET) begin
            state_q      <= S_CMD;
            pcnt_q       <= 2'd0;
            p0_q         <= 8'd0;
            p1_q         <= 8'd0;
            p2_q         <= 8'd0;
            xs_q         <= '0;
            xe_q         <= X_LAST;
            ys_q         <= '0;
            ye_q         <= Y_LAST;
            x_q          <= '0;
            y_q          <= '0;
            hi_flag_q    <= 1'b0;
            hi_byte_q    <= 8'd0;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_data_q   <= 16'd0;
            frame_done_q <= 1'b0;
            sleep_out_q  <= 1'b0;
            display_on_q <= 1'b0;
            inverted_q   <= 1'b0;
            colmod_q     <= 8'd0;
            madctl_q     <= 8'd0;
        end else begin
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            p0_q         <= p0_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            xs_q         <= xs_d;
            xe_q         <= xe_d;
            ys_q         <= ys_d;
            ye_q         <= ye_d;
            x_q          <= x_d;
            y_q          <= y_d;
            hi_flag_q    <= hi_flag_d;
            hi_byte_q    <= hi_byte_d;
            pix_valid_q  <= pix_valid_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_data_q   <= pix_data_d;
            frame_done_q <= frame_done_d;
            sleep_out_q  <= sleep_out_d;
            display_on_q <= display_on_d;
            inverted_q   <= inverted_d;
            colmod_q     <= colmod_d;
            madctl_q     <= madctl_d;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_data   = pix_data_q;
    assign frame_done = frame_done_q;
    assign sleep_out  = sleep_out_q;
    assign display_on = display_on_q;
    assign inverted   = inverted_q;
    assign colmod     = colmod_q;
    assign madctl     = madctl_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_st7735_panel_receiver.sv
// Directed bench for st7735_panel_receiver, using a reduced 16x8 panel so a
// full default-window frame stays short.
module tb_st7735_panel_receiver;
    import st7735_panel_receiver_pkg::*;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam int PW = 1 + XW + YW + 16;

    logic            clk = 1'b0;
    logic            sys_rst = 1'b1;
    logic            byte_valid, byte_is_cmd, pix_valid, frame_done;
    logic [7:0]      byte_data, colmod, madctl;
    logic [XW-1:0]   pix_x;
    logic [YW-1:0]   pix_y;
    logic [15:0]     pix_data;
    logic            sleep_out, display_on, inverted;
    state_t          dbg_state;

    st7735_panel_receiver_if spi_if ();

    st7735_panel_receiver #(
        .WIDTH (W), .HEIGHT (H), .SYNC_STAGES (2)
    ) dut (
        .SYSTEM_CLK   (clk),
        .SYSTEM_RESET (sys_rst),
        .spi          (spi_if.slave),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_is_cmd  (byte_is_cmd),
        .pix_valid    (pix_valid),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_data     (pix_data),
        .frame_done   (frame_done),
        .sleep_out    (sleep_out),
        .display_on   (display_on),
        .inverted     (inverted),
        .colmod       (colmod),
        .madctl       (madctl),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // ---------------- monitor ----------------
    logic [PW-1:0] pix_q[$];
    int            byte_cnt = 0;
    int            fd_cnt = 0;
    logic [7:0]    last_byte = 8'h00;
    logic          last_is_cmd = 1'b0;
    int            cyc = 0;
    int            last_byte_cyc = 0;
    int            pix_lag = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pix_valid) begin
            pix_lag = cyc - last_byte_cyc;
            pix_q.push_back({frame_done, pix_x, pix_y, pix_data});
        end
        if (frame_done) fd_cnt++;
        if (byte_valid) begin
            byte_cnt++;
            last_byte     = byte_data;
            last_is_cmd   = byte_is_cmd;
            last_byte_cyc = cyc;
        end
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // LCD_CLK period is 4 system clocks; all edges land on system negedges.
    task automatic send_bits(input logic [7:0] b, input int n, input logic dc);
        spi_if.CS = 1'b0;
        for (int i = 7; i > 7 - n; i--) begin
            spi_if.MOSI = b[i];
            spi_if.DC   = dc;
            repeat (2) @(negedge clk);
            spi_if.LCD_CLK = 1'b1;
            repeat (2) @(negedge clk);
            spi_if.LCD_CLK = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        send_bits(b, 8, dc);
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    task automatic send_pix(input logic [15:0] p);
        send_byte(p[15:8], 1'b1);
        send_byte(p[7:0], 1'b1);
    endtask

    logic [PW-1:0] got;
    logic [PW-1:0] exp_q[$];
    int            nb, nf;

    initial begin
        spi_if.CS = 1'b1;
        spi_if.LCD_CLK = 1'b0;
        spi_if.MOSI = 1'b0;
        spi_if.DC = 1'b0;
        spi_if.RESET = 1'b1;
        repeat (4) @(negedge clk);
        sys_rst = 1'b0;
        repeat (4) @(negedge clk);

        // reset state
        check("rst_byte_valid", 32'(byte_valid), 32'd0);
        check("rst_pix_valid",  32'(pix_valid),  32'd0);
        check("rst_byte_data",  32'(byte_data),  32'h00);
        check("rst_flags",      {29'd0, sleep_out, display_on, inverted}, 32'd0);
        check("rst_colmod",     32'(colmod), 32'h00);
        check("rst_madctl",     32'(madctl), 32'h00);
        check("rst_state",      32'(dbg_state), 32'(S_CMD));

        // SLPOUT command
        send_byte(8'h11, 1'b0);
        settle();
        check("slpout_bytes", 32'(byte_cnt), 32'd1);
        check("slpout_data",  32'(last_byte), 32'h11);
        check("slpout_cmd",   32'(last_is_cmd), 32'd1);
        check("slpout_flag",  32'(sleep_out), 32'd1);

        // 2x1 window, 4 pixels
        send_byte(8'h2A, 1'b0);
        send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h03, 1'b1);
        send_byte(8'h2B, 1'b0);
        send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
        settle();
        pix_q.delete();
        nf = fd_cnt;
        send_byte(8'h2C, 1'b0);
        send_pix(16'h0F0F); send_pix(16'h1234); send_pix(16'hABCD); send_pix(16'hFFFF);
        settle();
        exp_q.delete();
        exp_q.push_back({1'b0, 4'd2, 3'd5, 16'h0F0F});
        exp_q.push_back({1'b1, 4'd3, 3'd5, 16'h1234});
        exp_q.push_back({1'b0, 4'd2, 3'd5, 16'hABCD});
        exp_q.push_back({1'b1, 4'd3, 3'd5, 16'hFFFF});
        check("win_pix_count", 32'(pix_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            got = (pix_q.size() > 0) ? pix_q.pop_front() : '0;
            check($sformatf("win_pix%0d", i), 32'(got), 32'(exp_q[i]));
        end
        check("win_frame_done", 32'(fd_cnt - nf), 32'd2);
        check("pix_after_byte", 32'(pix_lag), 32'd1);

        // partial byte dropped on CS high
        nb = byte_cnt;
        send_bits(8'h29, 5, 1'b0);
        spi_if.CS = 1'b1;
        settle();
        check("partial_no_byte", 32'(byte_cnt - nb), 32'd0);
        check("partial_disp", 32'(display_on), 32'd0);
        send_byte(8'h29, 1'b0);
        settle();
        check("dispon_byte", 32'(byte_cnt - nb), 32'd1);
        check("dispon_flag", 32'(display_on), 32'd1);

        // command aborts pending RAMWR high byte
        pix_q.delete();
        send_byte(8'h2C, 1'b0);
        send_byte(8'hAB, 1'b1);
        send_byte(8'h36, 1'b0);
        send_byte(8'h60, 1'b1);
        settle();
        check("abort_no_pix", 32'(pix_q.size()), 32'd0);
        check("madctl_val", 32'(madctl), 32'h60);
        check("madctl_state", 32'(dbg_state), 32'(S_SKIP));

        // panel RESET pin
        spi_if.RESET = 1'b0;
        settle();
        spi_if.RESET = 1'b1;
        settle();
        check("resx_flags", {29'd0, sleep_out, display_on, inverted}, 32'd0);
        check("resx_madctl", 32'(madctl), 32'h00);
        check("resx_state", 32'(dbg_state), 32'(S_CMD));

        // COLMOD, INVON then SWRESET
        send_byte(8'h3A, 1'b0);
        send_byte(8'h05, 1'b1);
        send_byte(8'h21, 1'b0);
        send_byte(8'h11, 1'b0);
        settle();
        check("colmod_val", 32'(colmod), 32'h05);
        check("invon_flag", 32'(inverted), 32'd1);
        check("slpout2_flag", 32'(sleep_out), 32'd1);
        send_byte(8'h01, 1'b0);
        settle();
        check("swrst_flags", {29'd0, sleep_out, display_on, inverted}, 32'd0);
        check("swrst_colmod", 32'(colmod), 32'h00);
        check("swrst_byte_data", 32'(byte_data), 32'h00);

        // full default-window frame
        pix_q.delete();
        nf = fd_cnt;
        send_byte(8'h2C, 1'b0);
        for (int i = 0; i < W * H; i++) send_pix(16'h0F0F);
        settle();
        check("frame_count", 32'(pix_q.size()), 32'(W * H));
        for (int yy = 0; yy < H; yy++) begin
            for (int xx = 0; xx < W; xx++) begin
                got = (pix_q.size() > 0) ? pix_q.pop_front() : '0;
                check($sformatf("frame_pix_%0d_%0d", xx, yy), 32'(got),
                      32'({(xx == W - 1 && yy == H - 1), XW'(xx), YW'(yy), 16'h0F0F}));
            end
        end
        check("frame_done_once", 32'(fd_cnt - nf), 32'd1);

        // SYSTEM_RESET in the middle of a RAMWR
        send_byte(8'h11, 1'b0);
        send_byte(8'h2C, 1'b0);
        send_pix(16'h1111);
        send_byte(8'h22, 1'b1);
        spi_if.CS = 1'b1;
        repeat (3) @(negedge clk);
        #2 sys_rst = 1'b1;
        #4 sys_rst = 1'b0;
        @(negedge clk);
        check("sysrst_pix_valid", 32'(pix_valid), 32'd0);
        check("sysrst_pix_xy", 32'({pix_x, pix_y}), 32'd0);
        check("sysrst_flags", {29'd0, sleep_out, display_on, inverted}, 32'd0);
        check("sysrst_byte_data", 32'(byte_data), 32'h00);
        check("sysrst_state", 32'(dbg_state), 32'(S_CMD));
        pix_q.delete();
        send_byte(8'h2C, 1'b0);
        send_pix(16'h5555);
        settle();
        check("post_rst_count", 32'(pix_q.size()), 32'd1);
        got = (pix_q.size() > 0) ? pix_q.pop_front() : '0;
        check("post_rst_pix", 32'(got), 32'({1'b0, 4'd0, 3'd0, 16'h5555}));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Safety net against a stuck run.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
